// File: rtl/serial_tx_arbiter_if.sv
// Requester-side bus of serial_tx_arbiter: ownership request/release plus the
// per-requester byte ready/valid lanes. The arbiter uses the slave modport.
interface serial_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   i_req;
    logic [NUM_REQ-1:0]   i_release;
    logic [NUM_REQ-1:0]   i_byte_valid;
    logic [8*NUM_REQ-1:0] i_byte_data;
    logic [NUM_REQ-1:0]   o_byte_ready;
    logic [NUM_REQ-1:0]   o_grant;

    modport slave (
        input  i_req, i_release, i_byte_valid, i_byte_data,
        output o_byte_ready, o_grant
    );

    modport master (
        output i_req, i_release, i_byte_valid, i_byte_data,
        input  o_byte_ready, o_grant
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin owner of the single UART transmitter; paces bytes on tx_active.
// Optional idle-grant watchdog enabled by defining SERIAL_TX_ARB_WATCHDOG_EN.
module serial_tx_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int WATCHDOG_CYCLES = 1048576
) (
    input  logic                clock,
    input  logic                reset,
    serial_tx_arbiter_if.slave  bus,
    output logic                o_tx_valid,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_active,
    output logic                o_busy,
    output logic                o_watchdog_fired,
    output logic [1:0]          o_state
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a byte moves when byte_valid[i] & byte_ready[i] are both high
    // at a clock edge; ready is only ever raised for the owner in GRANTED.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BYTE    = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    state_t             r_state, w_next_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_last_owner;
    logic [IDX_W-1:0]   w_winner, w_cand;
    logic               w_found;
    logic               r_release_pending;
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;
    logic               w_own_valid, w_own_release;
    logic [7:0]         w_own_byte;
    logic               w_grant_new, w_accept, w_drop, w_set_pending;
    logic               w_wd_expire;

    always_comb begin
        w_own_valid   = 1'b0;
        w_own_release = 1'b0;
        w_own_byte    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_valid   = bus.i_byte_valid[i];
                w_own_release = bus.i_release[i];
                w_own_byte    = bus.i_byte_data[8*i +: 8];
            end
        end
    end

    // Search starts just past the previous owner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_owner;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_last_owner) + k) % NUM_REQ);
            if (!w_found && bus.i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant_new   = 1'b0;
        w_accept      = 1'b0;
        w_drop        = 1'b0;
        w_set_pending = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && !i_tx_active) begin
                    w_grant_new  = 1'b1;
                    w_next_state = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (w_own_valid) begin
                    w_accept      = 1'b1;
                    w_set_pending = w_own_release;
                    w_next_state  = ST_BYTE;
                end else if (w_own_release || w_wd_expire) begin
                    w_drop       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_BYTE: begin
                w_set_pending = w_own_release;
                w_next_state  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_tx_active) begin
                    if (r_release_pending || w_own_release) begin
                        w_drop       = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_GRANTED;
                    end
                end else begin
                    w_set_pending = w_own_release;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant           <= '0;
            r_last_owner      <= IDX_W'(NUM_REQ - 1);
            r_tx_valid        <= 1'b0;
            r_tx_data         <= '0;
            r_release_pending <= 1'b0;
        end else begin
            r_tx_valid <= w_accept;
            if (w_accept) r_tx_data <= w_own_byte;
            if (w_grant_new) begin
                r_grant      <= NUM_REQ'(1) << w_winner;
                r_last_owner <= w_winner;
            end else if (w_drop) begin
                r_grant <= '0;
            end
            if (w_drop)             r_release_pending <= 1'b0;
            else if (w_set_pending) r_release_pending <= 1'b1;
        end
    end

`ifdef SERIAL_TX_ARB_WATCHDOG_EN
    logic [20:0] r_wd_cnt;
    logic        r_wd_fired;

    assign w_wd_expire = (r_state == ST_GRANTED) && !w_own_valid && !w_own_release
                         && (r_wd_cnt == 21'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_cnt   <= '0;
            r_wd_fired <= 1'b0;
        end else begin
            r_wd_fired <= w_wd_expire;
            if (r_state == ST_GRANTED && w_next_state == ST_GRANTED) r_wd_cnt <= r_wd_cnt + 21'd1;
            else                                                    r_wd_cnt <= '0;
        end
    end

    assign o_watchdog_fired = r_wd_fired;
`else
    assign w_wd_expire      = 1'b0;
    assign o_watchdog_fired = 1'b0;
`endif

    assign bus.o_grant      = r_grant;
    assign bus.o_byte_ready = (r_state == ST_GRANTED) ? r_grant : '0;
    assign o_tx_valid       = r_tx_valid;
    assign o_tx_data        = r_tx_data;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_state          = r_state;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with a small UART busy model and a byte scoreboard.
// Define SERIAL_TX_ARB_WATCHDOG_EN to also exercise the watchdog (WATCHDOG_CYCLES=16).
module tb_serial_tx_arbiter;
    localparam int UART_LEN = 4;

    logic        clock;
    logic        reset;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_active;
    logic        o_busy;
    logic        o_watchdog_fired;
    logic [1:0]  o_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          uart_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] sb_exp;

    serial_tx_arbiter_if #(.NUM_REQ(3)) bus ();

    serial_tx_arbiter #(.NUM_REQ(3), .WATCHDOG_CYCLES(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .o_tx_valid       (o_tx_valid),
        .o_tx_data        (o_tx_data),
        .i_tx_active      (i_tx_active),
        .o_busy           (o_busy),
        .o_watchdog_fired (o_watchdog_fired),
        .o_state          (o_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // UART model: busy for UART_LEN cycles starting the cycle after tx_valid; ignores reset
    always @(posedge clock) begin
        if (o_tx_valid)        uart_cnt <= UART_LEN;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
    assign i_tx_active = (uart_cnt != 0);

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_ready(input int idx, input string tag);
        int t;
        t = 0;
        while (!bus.o_byte_ready[idx] && t < 40) begin
            tick(1);
            t++;
        end
        check(tag, 32'(bus.o_byte_ready[idx]), 32'd1);
    endtask

    // scoreboard: every transmitted byte must be the next expected one
    always @(negedge clock) begin
        if (o_tx_valid) begin
            if (exp_q.size() != 0) sb_exp = {24'd0, exp_q.pop_front()};
            else                   sb_exp = 32'hBAD;
            check("sb_tx_byte", 32'(o_tx_data), sb_exp);
        end
    end

    initial begin
        int n;
        int idx_list[4];
        idx_list = '{0, 1, 2, 0};

        reset            = 1'b1;
        bus.i_req        = '0;
        bus.i_release    = '0;
        bus.i_byte_valid = '0;
        bus.i_byte_data  = '0;
        tick(2);
        check("rst_grant", 32'(bus.o_grant), 32'd0);
        check("rst_ready", 32'(bus.o_byte_ready), 32'd0);
        check("rst_txv", 32'(o_tx_valid), 32'd0);
        check("rst_txd", 32'(o_tx_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wd", 32'(o_watchdog_fired), 32'd0);
        check("rst_state", 32'(o_state), 32'd0);

        // single owner streams two bytes
        reset     = 1'b0;
        bus.i_req = 3'b010;
        tick(1);
        check("t1_grant", 32'(bus.o_grant), 32'd2);
        check("t1_ready", 32'(bus.o_byte_ready), 32'd2);
        check("t1_busy", 32'(o_busy), 32'd1);
        bus.i_byte_valid = 3'b010;
        bus.i_byte_data  = 24'h004100;
        exp_q.push_back(8'h41);
        tick(1);
        bus.i_byte_valid = '0;
        check("t1_txv1", 32'(o_tx_valid), 32'd1);
        check("t1_txd1", 32'(o_tx_data), 32'h41);
        check("t1_ready_byte", 32'(bus.o_byte_ready), 32'd0);
        tick(1);
        check("t1_txv_wait", 32'(o_tx_valid), 32'd0);
        bus.i_byte_valid = 3'b010;
        bus.i_byte_data  = 24'h004200;
        exp_q.push_back(8'h42);
        n = 0;
        while (!o_tx_valid && n < 40) begin
            tick(1);
            n++;
        end
        bus.i_byte_valid = '0;
        check("t1_gap", 32'(n), 32'd6);
        check("t1_txd2", 32'(o_tx_data), 32'h42);
        wait_ready(1, "t1_back_ready");
        bus.i_release = 3'b010;
        tick(1);
        bus.i_release = '0;
        bus.i_req     = '0;
        check("t1_rel_grant", 32'(bus.o_grant), 32'd0);
        check("t1_rel_busy", 32'(o_busy), 32'd0);

        // round robin with all three requesting from reset
        reset = 1'b1;
        tick(1);
        reset     = 1'b0;
        bus.i_req = 3'b111;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check("t2_grant", 32'(bus.o_grant), 32'd1 << idx_list[i]);
            bus.i_byte_valid = 3'(1 << idx_list[i]);
            bus.i_byte_data  = {3{8'(8'h60 + i)}};
            exp_q.push_back(8'(8'h60 + i));
            tick(1);
            bus.i_byte_valid = '0;
            wait_ready(idx_list[i], "t2_ready");
            bus.i_release = 3'(1 << idx_list[i]);
            tick(1);
            bus.i_release = '0;
            check("t2_gap_grant", 32'(bus.o_grant), 32'd0);
            if (i == 3) bus.i_req = '0;
            tick(1);
        end

        // byte and release in the same cycle
        bus.i_req = 3'b001;
        tick(1);
        check("t3_grant", 32'(bus.o_grant), 32'd1);
        bus.i_byte_valid = 3'b001;
        bus.i_byte_data  = 24'h000055;
        bus.i_release    = 3'b001;
        exp_q.push_back(8'h55);
        tick(1);
        bus.i_byte_valid = '0;
        bus.i_release    = '0;
        bus.i_req        = '0;
        check("t3_txv", 32'(o_tx_valid), 32'd1);
        check("t3_txd", 32'(o_tx_data), 32'h55);
        check("t3_grant_held", 32'(bus.o_grant), 32'd1);
        tick(5);
        check("t3_grant_wait", 32'(bus.o_grant), 32'd1);
        check("t3_busy_wait", 32'(o_busy), 32'd1);
        tick(1);
        check("t3_grant_clr", 32'(bus.o_grant), 32'd0);
        check("t3_state_idle", 32'(o_state), 32'd0);

        // non-owner traffic is ignored
        bus.i_req        = 3'b001;
        bus.i_byte_valid = 3'b100;
        bus.i_byte_data  = 24'hFF0000;
        tick(1);
        check("t4_grant", 32'(bus.o_grant), 32'd1);
        check("t4_ready", 32'(bus.o_byte_ready), 32'd1);
        bus.i_byte_valid = 3'b101;
        bus.i_byte_data  = 24'hFF0011;
        bus.i_release    = 3'b100;
        exp_q.push_back(8'h11);
        tick(1);
        bus.i_release    = '0;
        bus.i_byte_valid = 3'b100;
        check("t4_txd", 32'(o_tx_data), 32'h11);
        check("t4_grant_kept", 32'(bus.o_grant), 32'd1);
        wait_ready(0, "t4_back_ready");
        check("t4_ready_only0", 32'(bus.o_byte_ready), 32'd1);
        bus.i_release = 3'b001;
        tick(1);
        bus.i_release    = '0;
        bus.i_byte_valid = '0;
        bus.i_req        = '0;
        check("t4_rel_grant", 32'(bus.o_grant), 32'd0);
        check("t4_txd_stable", 32'(o_tx_data), 32'h11);

        // reset in the middle of a byte
        bus.i_req = 3'b001;
        tick(1);
        check("t5_grant", 32'(bus.o_grant), 32'd1);
        bus.i_byte_valid = 3'b001;
        bus.i_byte_data  = 24'h000077;
        exp_q.push_back(8'h77);
        tick(1);
        bus.i_byte_valid = '0;
        check("t5_txv", 32'(o_tx_valid), 32'd1);
        tick(1);
        check("t5_state_wait", 32'(o_state), 32'd3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_rst_grant", 32'(bus.o_grant), 32'd0);
        check("t5_rst_ready", 32'(bus.o_byte_ready), 32'd0);
        check("t5_rst_txv", 32'(o_tx_valid), 32'd0);
        check("t5_rst_txd", 32'(o_tx_data), 32'd0);
        check("t5_rst_busy", 32'(o_busy), 32'd0);
        n = 0;
        while (i_tx_active && n < 20) begin
            check("t5_no_grant_busy", 32'(bus.o_grant), 32'd0);
            tick(1);
            n++;
        end
        check("t5_uart_drain", 32'(n), 32'd3);
        check("t5_no_grant_yet", 32'(bus.o_grant), 32'd0);
        tick(1);
        check("t5_grant_after", 32'(bus.o_grant), 32'd1);
        bus.i_release = 3'b001;
        tick(1);
        bus.i_release = '0;
        bus.i_req     = '0;
        check("t5_rel_grant", 32'(bus.o_grant), 32'd0);

`ifdef SERIAL_TX_ARB_WATCHDOG_EN
        // owner 1 idles; watchdog hands the transmitter to requester 0
        bus.i_req = 3'b011;
        tick(1);
        check("wd_grant1", 32'(bus.o_grant), 32'd2);
        tick(15);
        check("wd_held", 32'(bus.o_grant), 32'd2);
        check("wd_quiet", 32'(o_watchdog_fired), 32'd0);
        tick(1);
        check("wd_fired", 32'(o_watchdog_fired), 32'd1);
        check("wd_grant_clr", 32'(bus.o_grant), 32'd0);
        tick(1);
        check("wd_pulse_end", 32'(o_watchdog_fired), 32'd0);
        check("wd_next_grant", 32'(bus.o_grant), 32'd1);
        bus.i_release = 3'b001;
        tick(1);
        bus.i_release = '0;
        bus.i_req     = '0;
`endif

        tick(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares the single UART transmitter between several byte-stream requesters: the sample data sender, the metadata sender and future status/test-mode sources. Each requester claims the transmitter for a whole frame and streams bytes through a ready/valid handshake. The block paces bytes against the transmitter's `active` flag and releases ownership on request. It replaces the state-indexed output mux in the top level, so the command sequencer only starts senders and no longer steers the serial port.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8; requester 0 = data sender, 1 = metadata sender.
- `WATCHDOG_CYCLES`, default 1048576: idle-grant timeout, used only with the watchdog macro.
- `clock`  in  1  system clock; reset reset, synchronous, active-high; clock clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NUM_REQ  level; requester i wants ownership.
- `release`  in  NUM_REQ  one-cycle pulse; owner gives up the transmitter.
- `byte_valid`  in  NUM_REQ  requester i offers a byte.
- `byte_data`  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- `byte_ready`  out  NUM_REQ  one-hot or zero; byte accepted when valid&ready.
- `grant`  out  NUM_REQ  registered, one-hot or zero; current owner.
- `tx_valid`  out  1  registered one-cycle strobe to the UART transmitter.
- `tx_data`  out  8  registered byte, valid while tx_valid=1.
- `tx_active`  in  1  UART busy; rises the cycle after tx_valid, low when idle.
- `busy`  out  1  state != IDLE.
- `watchdog_fired`  out  1  one-cycle pulse; tied 0 without the macro.

## Operation
- States: IDLE, GRANTED, BYTE, WAIT.
- IDLE: grant=0. If any req bit is set and tx_active=0, pick the winner round-robin, searching from (last_owner+1) mod NUM_REQ. Set grant, then go to GRANTED. last_owner resets to NUM_REQ-1, so requester 0 wins first.
- GRANTED: byte_ready[owner]=1, all other bits 0.
  - byte_valid[owner]: latch byte_data[owner] into tx_data, set tx_valid, go to BYTE.
  - Else release[owner]: clear grant, go to IDLE.
- BYTE: exactly one cycle with tx_valid=1, then go to WAIT.
- WAIT: stay while tx_active=1. On the first cycle tx_active=0, go to GRANTED, or to IDLE if a release is pending.
- release[owner] in BYTE/WAIT, or in the same cycle as an accepted byte, sets release_pending. The byte still completes, then the block goes to IDLE. Grant stays held until that point.
- Inputs from non-owners are ignored: byte_valid, release. Deasserting req[owner] does not revoke the grant; only release, the watchdog or reset do.
- Bytes are never dropped or duplicated. tx_data is stable from BYTE until the next acceptance.
- Reset: every output goes to 0, state to IDLE, release_pending to 0. A byte already inside the UART finishes on its own. No new grant is issued until tx_active=0.

## Timing
- Grant latency: req rises at cycle N in IDLE with tx_active=0 → grant and byte_ready at N+1.
- Byte path: accepted at N → tx_valid at N+1 (BYTE) → WAIT from N+2. tx_active=1 is sampled at N+2, as guaranteed by the UART.
- Next byte_ready: the cycle after WAIT sees tx_active=0.
- Release: in GRANTED at N → grant=0 at N+1. Next arbitration at N+1, new grant at N+2. One idle cycle between owners.
- Simultaneous requests: the lowest index after last_owner wins; the others wait without starvation.

## Configuration
- `SERIAL_TX_ARB_WATCHDOG_EN` defined:
  - A 21-bit counter counts cycles in GRANTED with no byte acceptance.
  - It clears on acceptance or on leaving GRANTED.
  - Reaching WATCHDOG_CYCLES clears grant, goes to IDLE and pulses watchdog_fired for one cycle.
  - last_owner updates normally.
- Undefined: no counter; watchdog_fired is tied to 0; a grant is held indefinitely.

## Test plan
- Reset then req=3'b010 → grant=3'b010 the next cycle. Stream bytes 0x41,0x42 → tx_valid pulses once per byte with tx_data 0x41 then 0x42. The second pulse is no earlier than the cycle after tx_active falls.
- req=3'b111 from reset, each owner sends 1 byte then releases → grant order 001, 010, 100, 001. One cycle with grant=0 between owners.
- Owner asserts byte_valid(0x55) and release in the same cycle → 0x55 is transmitted. grant clears the cycle after WAIT sees tx_active=0.
- Non-owner requester 2 drives byte_valid=1, byte 0xFF, throughout owner 0's frame → 0xFF never appears on tx_data; byte_ready[2]=0 throughout.
- Reset asserted mid-byte while tx_active=1, req=3'b001 held → all outputs 0 immediately. grant=001 only the cycle after tx_active falls.
- With the macro and WATCHDOG_CYCLES=16: owner is granted and sends nothing → watchdog_fired pulses after 16 GRANTED cycles, grant clears, and the next requester is granted.
